writeback_stage: RTL
====================

Name: writeback_stage

Overview:
Final pipeline stage, directly downstream of the memory-access stage. Holds the MEM/WB pipeline register and selects the write-back result via `result_src`. Drives the integer and FP register-file write ports. Consumes input-port data with a valid/ready handshake and counts retired instructions.

Parameters:
CNT_W, 64, width of retired-instruction counter
IN_SRC, 3'd5, result_src code selecting input-port data

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
stall  in  1  hazard unit: freeze MEM/WB register
flush  in  1  hazard unit: load bubble into MEM/WB register
valid_m  in  1  memory stage holds a real instruction
reg_write_m  in  1  integer register write enable
fpu_reg_write_m  in  1  FP register write enable
result_src_m  in  3  result select
rd_m  in  5  destination register index
alu_result_m  in  32  ALU result
read_data_m  in  32  data-memory load data
pc_plus4_m  in  32  PC+4
imm_ext_m  in  32  extended immediate
fpu_result_m  in  32  FPU result
rd1_m  in  32  integer source 1 (int->FP move)
fpu_rd1_m  in  32  FP source 1 (FP->int move)
in_data  in  32  input-port data
in_valid  in  1  input-port data available
in_ready  out  1  input-port data consumed this cycle
reg_write_w  out  1  integer register-file write strobe
fpu_reg_write_w  out  1  FP register-file write strobe
rd_w  out  5  write index
result_w  out  32  write data (also the forwarding source)
wb_busy  out  1  stall request to all upstream stages
instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset (async, rstn=0): all MEM/WB register fields are 0. Internal `valid` and `done` are 0. `instret` is 0. All outputs are 0.
- Register update on rising clk edge, in priority order:
  - wb_busy=1: hold all fields.
  - flush=1: valid<=0, done<=0.
  - stall=1: hold fields; done<=done|retire.
  - otherwise: load all *_m fields, valid<=valid_m, done<=0.
- `flush` is ignored while wb_busy=1. An entry waiting on the input port always completes.
- Result mux (combinational from the register):
  - 0 alu_result
  - 1 read_data
  - 2 pc_plus4
  - 3 imm_ext
  - 4 fpu_result
  - 5 in_data
  - 6 rd1
  - 7 fpu_rd1
- `live` = valid & !done.
- `wait_in` = live & (result_src==IN_SRC) & !in_valid.
- wb_busy = wait_in.
- in_ready = live & (result_src==IN_SRC) & in_valid. It is high for exactly one cycle per input instruction.
- retire = live & !wait_in.
- reg_write_w = retire & reg_write & (rd!=0). Writes to x0 are suppressed.
- fpu_reg_write_w = retire & fpu_reg_write. f0 is writable.
- rd_w and result_w always reflect the register, even when no write strobe is active.
- `done` guarantees a held (stalled) entry writes and counts exactly once.
- instret increments by 1 on each cycle with retire=1. It wraps modulo 2^CNT_W.
- Latency: result is visible and written in the cycle after the instruction leaves the memory stage (the input-port wait adds cycles).
- Reset asserted mid-wait: in_ready drops immediately and no write occurs.

Test Plan:
- ALU op, result_src=0, rd=5, alu_result=0x0000_1234 → next cycle: reg_write_w=1, rd_w=5, result_w=0x1234; instret=1 after the following edge.
- Write to x0 (rd=0, reg_write=1) → reg_write_w=0 while result_w still shows the value; an FP write to f0 gives fpu_reg_write_w=1.
- Input op, result_src=5, in_valid=0 for 3 cycles → wb_busy=1 and no write for 3 cycles; flush asserted during the wait is ignored. Then in_valid=1, in_data=0xDEADBEEF → one cycle with in_ready=1, reg_write_w=1, result_w=0xDEADBEEF, wb_busy=0.
- ALU op retires, then stall held 4 cycles → exactly one write strobe; instret +1 only.
- flush with valid_m=1 → no write strobe next cycle, instret unchanged. result_src 6/7 (rd1=0x3F800000 into FP, fpu_rd1=0x40000000 into int) → correct write port and value.
- rstn pulled low asynchronously mid-wait → all outputs 0 before the next clk edge; instret=0.

Source files
------------

// File: rtl/writeback_stage.sv
// writeback_stage
//   Final pipeline stage. Holds the MEM/WB pipeline register, selects the
//   write-back value with result_src and drives the integer and FP
//   register-file write ports. Instructions that read the input port wait
//   here (holding the whole pipeline through wb_busy) until in_valid is seen.
//   Retired instructions are counted in instret.
//
// Ports
//   clk, rstn               clock, asynchronous active-low reset
//   stall, flush            hazard unit controls for the MEM/WB register
//   *_m                     instruction fields from the memory stage
//   in_data/in_valid        input-port data and its availability
//   in_ready                input-port data consumed this cycle
//   reg_write_w             integer register-file write strobe (x0 suppressed)
//   fpu_reg_write_w         FP register-file write strobe
//   rd_w, result_w          write index and data (also the forwarding source)
//   wb_busy                 stall request to all upstream stages
//   instret                 retired-instruction count (wraps)
module writeback_stage #(
  parameter int         CNT_W  = 64,
  parameter logic [2:0] IN_SRC = 3'd5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             stall,
  input  logic             flush,
  input  logic             valid_m,
  input  logic             reg_write_m,
  input  logic             fpu_reg_write_m,
  input  logic [2:0]       result_src_m,
  input  logic [4:0]       rd_m,
  input  logic [31:0]      alu_result_m,
  input  logic [31:0]      read_data_m,
  input  logic [31:0]      pc_plus4_m,
  input  logic [31:0]      imm_ext_m,
  input  logic [31:0]      fpu_result_m,
  input  logic [31:0]      rd1_m,
  input  logic [31:0]      fpu_rd1_m,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             reg_write_w,
  output logic             fpu_reg_write_w,
  output logic [4:0]       rd_w,
  output logic [31:0]      result_w,
  output logic             wb_busy,
  output logic [CNT_W-1:0] instret
);

  // MEM/WB register
  logic             valid_reg;
  logic             done_reg;
  logic             reg_write_reg;
  logic             fpu_reg_write_reg;
  logic [2:0]       result_src_reg;
  logic [4:0]       rd_reg;
  logic [31:0]      alu_result_reg;
  logic [31:0]      read_data_reg;
  logic [31:0]      pc_plus4_reg;
  logic [31:0]      imm_ext_reg;
  logic [31:0]      fpu_result_reg;
  logic [31:0]      rd1_reg;
  logic [31:0]      fpu_rd1_reg;
  logic [CNT_W-1:0] instret_reg;

  logic live;
  logic is_in;
  logic wait_in;
  logic retire;

  // done marks an entry that already wrote while being held by stall, so a
  // frozen entry neither writes nor counts a second time.
  assign live    = valid_reg & ~done_reg;
  assign is_in   = (result_src_reg == IN_SRC);
  assign wait_in = live & is_in & ~in_valid;
  assign retire  = live & ~wait_in;

  assign wb_busy         = wait_in;
  assign in_ready        = live & is_in & in_valid;
  assign reg_write_w     = retire & reg_write_reg & (rd_reg != 5'd0);
  assign fpu_reg_write_w = retire & fpu_reg_write_reg;
  assign rd_w            = rd_reg;
  assign instret         = instret_reg;

  // Result select as a one-hot AND-OR over the eight candidate sources.
  // Source 5 is the live input port, not a registered value.
  logic [31:0] mux_in     [8];
  logic [31:0] mux_masked [8];

  assign mux_in[0] = alu_result_reg;
  assign mux_in[1] = read_data_reg;
  assign mux_in[2] = pc_plus4_reg;
  assign mux_in[3] = imm_ext_reg;
  assign mux_in[4] = fpu_result_reg;
  assign mux_in[5] = in_data;
  assign mux_in[6] = rd1_reg;
  assign mux_in[7] = fpu_rd1_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_sel
      assign mux_masked[gi] = (result_src_reg == 3'(gi)) ? mux_in[gi] : 32'd0;
    end
  endgenerate

  always_comb begin
    result_w = 32'd0;
    for (int i = 0; i < 8; i++) begin
      result_w = result_w | mux_masked[i];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_reg         <= 1'b0;
      done_reg          <= 1'b0;
      reg_write_reg     <= 1'b0;
      fpu_reg_write_reg <= 1'b0;
      result_src_reg    <= 3'd0;
      rd_reg            <= 5'd0;
      alu_result_reg    <= 32'd0;
      read_data_reg     <= 32'd0;
      pc_plus4_reg      <= 32'd0;
      imm_ext_reg       <= 32'd0;
      fpu_result_reg    <= 32'd0;
      rd1_reg           <= 32'd0;
      fpu_rd1_reg       <= 32'd0;
      instret_reg       <= '0;
    end else begin
      if (retire) begin
        instret_reg <= instret_reg + CNT_W'(1);
      end
      // While waiting on the input port nothing may displace the entry,
      // not even a flush: the waiting instruction always completes.
      if (wait_in) begin
        valid_reg <= valid_reg;
      end else if (flush) begin
        valid_reg <= 1'b0;
        done_reg  <= 1'b0;
      end else if (stall) begin
        done_reg <= done_reg | retire;
      end else begin
        valid_reg         <= valid_m;
        done_reg          <= 1'b0;
        reg_write_reg     <= reg_write_m;
        fpu_reg_write_reg <= fpu_reg_write_m;
        result_src_reg    <= result_src_m;
        rd_reg            <= rd_m;
        alu_result_reg    <= alu_result_m;
        read_data_reg     <= read_data_m;
        pc_plus4_reg      <= pc_plus4_m;
        imm_ext_reg       <= imm_ext_m;
        fpu_result_reg    <= fpu_result_m;
        rd1_reg           <= rd1_m;
        fpu_rd1_reg       <= fpu_rd1_m;
      end
    end
  end

endmodule
